// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and segment encodings for the scanned seven-segment driver
// Contents: state_t (conversion FSM states), nibble_t (one BCD/hex digit),
//           SEG_* active-low {a,b,c,d,e,f,g} patterns, seg_encode() lookup.
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] nibble_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   function automatic logic [6:0] seg_encode(input nibble_t n);
      case (n)
         4'h0:    return SEG_0;
         4'h1:    return SEG_1;
         4'h2:    return SEG_2;
         4'h3:    return SEG_3;
         4'h4:    return SEG_4;
         4'h5:    return SEG_5;
         4'h6:    return SEG_6;
         4'h7:    return SEG_7;
         4'h8:    return SEG_8;
         4'h9:    return SEG_9;
         4'hA:    return SEG_A;
         4'hB:    return SEG_B;
         4'hC:    return SEG_C;
         4'hD:    return SEG_D;
         4'hE:    return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - display-side signal bundle between game logic and the scan driver
// Signals: value/dp_mask (and hex_mode when SSD_HEX_MODE_EN) from game logic;
//          anode/ssdOut/dp toward the board pins, busy back to game logic.
// Modports: master = game logic / bench side, slave = ssd_scan_driver.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 16
);
   logic [VALUE_W-1:0]    value;
   logic [NUM_DIGITS-1:0] dp_mask;
`ifdef SSD_HEX_MODE_EN
   logic                  hex_mode;
`endif
   logic [NUM_DIGITS-1:0] anode;
   logic [6:0]            ssdOut;
   logic                  dp;
   logic                  busy;

`ifdef SSD_HEX_MODE_EN
   modport master (output value, dp_mask, hex_mode, input anode, ssdOut, dp, busy);
   modport slave  (input value, dp_mask, hex_mode, output anode, ssdOut, dp, busy);
`else
   modport master (output value, dp_mask, input anode, ssdOut, dp, busy);
   modport slave  (input value, dp_mask, output anode, ssdOut, dp, busy);
`endif

endinterface

// File: rtl/ssd_bin2bcd.sv
// rtl/ssd_bin2bcd.sv - sequential double-dabble binary to BCD converter
// Ports: clk, reset (sync, active-high); start/din (and hex when SSD_HEX_MODE_EN) in;
//        busy (SHIFT or DONE), done (DONE, result valid), bcd, ovf (value >= 10^NUM_DIGITS) out.
// Optional: SSD_HEX_MODE_EN adds hex, which loads raw nibbles and skips SHIFT.
module ssd_bin2bcd
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [VALUE_W-1:0]      din,
`ifdef SSD_HEX_MODE_EN
   input  logic                    hex,
`endif
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(VALUE_W + 1);

   state_t             state_q, state_d;
   logic [VALUE_W-1:0] sh_q, sh_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef SSD_HEX_MODE_EN
   localparam int EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
   logic [EXT_W-1:0] ext;
   assign ext = EXT_W'(din);
`endif

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      for (int i = 0; i < NUM_DIGITS; i++) begin
         adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = din;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef SSD_HEX_MODE_EN
               if (hex) begin
                  bcd_d   = ext[BCD_W-1:0];
                  ovf_d   = |(ext >> BCD_W);
                  state_d = DONE;
               end
`endif
            end
         end
         SHIFT: begin
            // The bit leaving the top nibble is a digit the display cannot hold.
            bcd_d = {adj[BCD_W-2:0], sh_q[VALUE_W-1]};
            ovf_d = ovf_q | adj[BCD_W-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(VALUE_W - 1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - binary value to time-multiplexed seven-segment display driver
// Ports: clk, reset (sync, active-high); bus (ssd_scan_driver_if.slave):
//        value, dp_mask in; anode (active-low, bit 0 rightmost), ssdOut {a..g} and dp
//        (active-low), busy (conversion in progress) out.
// Optional: SSD_HEX_MODE_EN adds bus.hex_mode for raw hexadecimal display.
// The interface instance must carry the same NUM_DIGITS/VALUE_W as this module.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_W     = 16,
   parameter int REFRESH_DIV = 100000
) (
   input logic                clk,
   input logic                reset,
   ssd_scan_driver_if.slave   bus
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [VALUE_W-1:0]      last_value;
   logic                    changed;
   logic                    conv_busy, conv_done, conv_ovf;
   logic [4*NUM_DIGITS-1:0] conv_bcd;
   logic [NUM_DIGITS-1:0]   blank_new;
   logic                    run_zero;

   nibble_t [NUM_DIGITS-1:0] disp_q, disp_d;
   logic [NUM_DIGITS-1:0]    blank_q, blank_d;
   logic                     ovf_q, ovf_d;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

`ifdef SSD_HEX_MODE_EN
   logic last_hex;
   assign changed = (bus.value != last_value) || (bus.hex_mode != last_hex);
`else
   assign changed = (bus.value != last_value);
`endif

   ssd_bin2bcd #(
      .NUM_DIGITS (NUM_DIGITS),
      .VALUE_W    (VALUE_W)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (changed),
      .din   (bus.value),
`ifdef SSD_HEX_MODE_EN
      .hex   (bus.hex_mode),
`endif
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   // Leading-zero run from the top digit down; digit 0 always stays lit.
   always_comb begin
      blank_new = '0;
      run_zero  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         run_zero     = run_zero && (conv_bcd[4*k +: 4] == 4'd0);
         blank_new[k] = run_zero;
      end
   end

   // Outputs are registered from next-state values so anode, segments and dp
   // change together and a fresh commit appears without an extra cycle.
   always_comb begin
      disp_d  = disp_q;
      blank_d = blank_q;
      ovf_d   = ovf_q;
      if (conv_done) begin
         disp_d  = conv_bcd;
         blank_d = blank_new;
         ovf_d   = conv_ovf;
      end

      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      anode_d = ~(NUM_DIGITS'(1) << idx_d);
      if (ovf_d) begin
         seg_d = SEG_DASH;
      end else if (blank_d[idx_d]) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = seg_encode(disp_d[idx_d]);
      end
      dp_d = ~bus.dp_mask[idx_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_value <= '0;
`ifdef SSD_HEX_MODE_EN
         last_hex   <= 1'b0;
`endif
         disp_q     <= '0;
         blank_q    <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         anode_q    <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         // Track the value only when the converter accepts it; changes
         // arriving mid-conversion are picked up once it is idle again.
         if (changed && !conv_busy) begin
            last_value <= bus.value;
`ifdef SSD_HEX_MODE_EN
            last_hex   <= bus.hex_mode;
`endif
         end
         disp_q  <= disp_d;
         blank_q <= blank_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.anode  = anode_q;
   assign bus.ssdOut = seg_q;
   assign bus.dp     = dp_q;
   assign bus.busy   = conv_busy;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver (4 digits, 16-bit, div 4)
module tb_ssd_scan_driver;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ssd_scan_driver_if #(.NUM_DIGITS(4), .VALUE_W(16)) bus ();

   ssd_scan_driver #(
      .NUM_DIGITS  (4),
      .VALUE_W     (16),
      .REFRESH_DIV (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   logic [3:0] prev_anode;
   logic [6:0] seg1234 [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      prev_anode = bus.anode;
      @(negedge clk);
   endtask

   task automatic wait_conv(input string tag, input int exp_len);
      int guard = 0;
      int n = 0;
      step();
      while (!bus.busy && guard < 8) begin
         step();
         guard++;
      end
      check_vec({tag, "_start"}, 32'(bus.busy), 32'd1);
      while (bus.busy && n < 64) begin
         n++;
         step();
      end
      check_vec({tag, "_busy_len"}, n, exp_len);
   endtask

   task automatic check_slot(input string tag, input logic [3:0] pat,
                             input logic [6:0] seg, input logic dpv);
      int guard = 0;
      int n = 0;
      while (!(bus.anode == pat && prev_anode != pat) && guard < 40) begin
         step();
         guard++;
      end
      check_vec({tag, "_found"}, 32'(bus.anode == pat), 32'd1);
      check_vec({tag, "_seg"}, 32'(bus.ssdOut), 32'(seg));
      check_vec({tag, "_dp"}, 32'(bus.dp), 32'(dpv));
      while (bus.anode == pat && n < 10) begin
         n++;
         step();
      end
      check_vec({tag, "_len"}, n, 4);
   endtask

   initial begin
      int n;
      int guard;
      int idx;

      reset       = 1'b1;
      bus.value   = '0;
      bus.dp_mask = '0;
`ifdef SSD_HEX_MODE_EN
      bus.hex_mode = 1'b0;
`endif
      prev_anode  = '1;

      // Reset state
      repeat (3) step();
      check_vec("rst_anode", 32'(bus.anode), 32'hF);
      check_vec("rst_seg", 32'(bus.ssdOut), 32'h7F);
      check_vec("rst_dp", 32'(bus.dp), 32'd1);
      check_vec("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      step();
      check_vec("post_rst_anode", 32'(bus.anode), 32'b1110);
      check_vec("post_rst_seg", 32'(bus.ssdOut), 32'b0000001);
      check_vec("post_rst_busy", 32'(bus.busy), 32'd0);

      // 1234
      bus.value = 16'd1234;
      wait_conv("v1234", 17);
      check_slot("v1234_d0", 4'b1110, 7'b1001100, 1'b1);
      check_slot("v1234_d1", 4'b1101, 7'b0000110, 1'b1);
      check_slot("v1234_d2", 4'b1011, 7'b0010010, 1'b1);
      check_slot("v1234_d3", 4'b0111, 7'b1001111, 1'b1);

      // 7 with decimal point on digit 2
      bus.value   = 16'd7;
      bus.dp_mask = 4'b0100;
      wait_conv("v7", 17);
      check_slot("v7_d0", 4'b1110, 7'b0001111, 1'b1);
      check_slot("v7_d1", 4'b1101, 7'b1111111, 1'b1);
      check_slot("v7_d2", 4'b1011, 7'b1111111, 1'b0);
      check_slot("v7_d3", 4'b0111, 7'b1111111, 1'b1);
      bus.dp_mask = 4'b0000;

      // Overflow
      bus.value = 16'd10000;
      wait_conv("v10000", 17);
      check_slot("ovf_d0", 4'b1110, 7'b1111110, 1'b1);
      check_slot("ovf_d1", 4'b1101, 7'b1111110, 1'b1);
      check_slot("ovf_d2", 4'b1011, 7'b1111110, 1'b1);
      check_slot("ovf_d3", 4'b0111, 7'b1111110, 1'b1);

      // Change during SHIFT: 1234 completes first, then 42
      bus.value = 16'd1234;
      step();
      guard = 0;
      while (!bus.busy && guard < 8) begin
         step();
         guard++;
      end
      check_vec("mid_start", 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         if (n == 5) bus.value = 16'd42;
         step();
      end
      check_vec("mid_first_len", n, 17);
      idx = 0;
      for (int i = 0; i < 4; i++) if (bus.anode[i] == 1'b0) idx = i;
      check_vec("mid_commit_1234", 32'(bus.ssdOut), 32'(seg1234[idx]));
      step();
      check_vec("mid_busy_reassert", 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         step();
      end
      check_vec("mid_second_len", n, 17);
      check_slot("v42_d0", 4'b1110, 7'b0010010, 1'b1);
      check_slot("v42_d1", 4'b1101, 7'b1001100, 1'b1);
      check_slot("v42_d2", 4'b1011, 7'b1111111, 1'b1);
      check_slot("v42_d3", 4'b0111, 7'b1111111, 1'b1);

      // Reset during SHIFT
      bus.value = 16'd999;
      step();
      guard = 0;
      while (!bus.busy && guard < 8) begin
         step();
         guard++;
      end
      check_vec("abort_start", 32'(bus.busy), 32'd1);
      step();
      step();
      reset     = 1'b1;
      bus.value = 16'd0;
      step();
      check_vec("abort_busy", 32'(bus.busy), 32'd0);
      check_vec("abort_anode", 32'(bus.anode), 32'hF);
      check_vec("abort_seg", 32'(bus.ssdOut), 32'h7F);
      check_vec("abort_dp", 32'(bus.dp), 32'd1);
      step();
      reset = 1'b0;
      step();
      check_vec("abort_rel_anode", 32'(bus.anode), 32'b1110);
      check_vec("abort_rel_seg", 32'(bus.ssdOut), 32'b0000001);
      repeat (20) step();
      check_vec("abort_idle_busy", 32'(bus.busy), 32'd0);
      check_slot("abort_d0", 4'b1110, 7'b0000001, 1'b1);

      bus.value = 16'd5;
      wait_conv("v5", 17);
      check_slot("v5_d0", 4'b1110, 7'b0100100, 1'b1);
      check_slot("v5_d1", 4'b1101, 7'b1111111, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
